// File: rtl/dma_if_32to64.sv
// AXI-Stream 32->64 width upconverter for the fromhost (MM2S) path.
// Pairs consecutive input dwords into one registered 64-bit beat; a packet-final odd dword is zero-padded.
module dma_if_32to64 #(
    parameter bit FIRST_IN_HIGH = 1'b1,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             s0_axis_fromhost_tvalid,
    input  logic [31:0]      s0_axis_fromhost_tdata,
    input  logic [3:0]       s0_axis_fromhost_tkeep,
    input  logic             s0_axis_fromhost_tlast,
    output logic             s0_axis_fromhost_tready,

    output logic             m0_axis_fromhost_tvalid,
    output logic [63:0]      m0_axis_fromhost_tdata,
    output logic [7:0]       m0_axis_fromhost_tkeep,
    output logic             m0_axis_fromhost_tlast,
    input  logic             m0_axis_fromhost_tready,

    output logic [CNT_W-1:0] pkt_cnt
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_HALF  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        hold_data_q, hold_data_d;
    logic [3:0]         hold_keep_q, hold_keep_d;
    logic               m_tvalid_q, m_tvalid_d;
    logic [63:0]        m_tdata_q, m_tdata_d;
    logic [7:0]         m_tkeep_q, m_tkeep_d;
    logic               m_tlast_q, m_tlast_d;
    logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;

    logic               s_ready;
    logic               s_hs;
    logic               m_hs;
    logic [31:0]        first_data, second_data;
    logic [3:0]         first_keep, second_keep;
    logic [63:0]        pair_data;
    logic [7:0]         pair_keep;

    // Accept whenever the output register is empty or is draining this cycle.
    assign s_ready = ~m_tvalid_q | m0_axis_fromhost_tready;
    assign s_hs    = s0_axis_fromhost_tvalid & s_ready;
    assign m_hs    = m_tvalid_q & m0_axis_fromhost_tready;

    // Slot assembly: in S_HALF the held dword goes first, otherwise the incoming one leads a zero pad.
    always_comb begin
        if (state_q == S_HALF) begin
            first_data  = hold_data_q;
            first_keep  = hold_keep_q;
            second_data = s0_axis_fromhost_tdata;
            second_keep = s0_axis_fromhost_tkeep;
        end else begin
            first_data  = s0_axis_fromhost_tdata;
            first_keep  = s0_axis_fromhost_tkeep;
            second_data = '0;
            second_keep = '0;
        end

        if (FIRST_IN_HIGH) begin
            pair_data = {first_data, second_data};
            pair_keep = {first_keep, second_keep};
        end else begin
            pair_data = {second_data, first_data};
            pair_keep = {second_keep, first_keep};
        end
    end

    always_comb begin
        // NOTE: every _d gets a hold/default value first so no path through the case leaves it unassigned (no latches).
        state_d     = state_q;
        hold_data_d = hold_data_q;
        hold_keep_d = hold_keep_q;
        m_tvalid_d  = m_tvalid_q & ~m_hs;
        m_tdata_d   = m_tdata_q;
        m_tkeep_d   = m_tkeep_q;
        m_tlast_d   = m_tlast_q;
        pkt_cnt_d   = pkt_cnt_q;

        if (m_hs && m_tlast_q) begin
            pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
        end

        if (s_hs) begin
            unique case (state_q)
                S_EMPTY: begin
                    if (s0_axis_fromhost_tlast) begin
                        m_tvalid_d = 1'b1;
                        m_tdata_d  = pair_data;
                        m_tkeep_d  = pair_keep;
                        m_tlast_d  = 1'b1;
                    end else begin
                        hold_data_d = s0_axis_fromhost_tdata;
                        hold_keep_d = s0_axis_fromhost_tkeep;
                        state_d     = S_HALF;
                    end
                end
                S_HALF: begin
                    m_tvalid_d = 1'b1;
                    m_tdata_d  = pair_data;
                    m_tkeep_d  = pair_keep;
                    m_tlast_d  = s0_axis_fromhost_tlast;
                    state_d    = S_EMPTY;
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_EMPTY;
            hold_data_q <= '0;
            hold_keep_q <= '0;
            m_tvalid_q  <= 1'b0;
            m_tdata_q   <= '0;
            m_tkeep_q   <= '0;
            m_tlast_q   <= 1'b0;
            pkt_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            hold_data_q <= hold_data_d;
            hold_keep_q <= hold_keep_d;
            m_tvalid_q  <= m_tvalid_d;
            m_tdata_q   <= m_tdata_d;
            m_tkeep_q   <= m_tkeep_d;
            m_tlast_q   <= m_tlast_d;
            pkt_cnt_q   <= pkt_cnt_d;
        end
    end

    assign s0_axis_fromhost_tready = s_ready;
    assign m0_axis_fromhost_tvalid = m_tvalid_q;
    assign m0_axis_fromhost_tdata  = m_tdata_q;
    assign m0_axis_fromhost_tkeep  = m_tkeep_q;
    assign m0_axis_fromhost_tlast  = m_tlast_q;
    assign pkt_cnt                 = pkt_cnt_q;

endmodule

// File: tb/tb_dma_if_32to64.sv
// Directed bench for dma_if_32to64: high-first instance for packing/stall/reset, low-first instance for order and counter wrap.
module tb_dma_if_32to64;

    localparam logic [31:0] DA = 32'hAAAA_0001;
    localparam logic [31:0] DB = 32'hBBBB_0002;
    localparam logic [31:0] DC = 32'hCCCC_0003;
    localparam logic [31:0] DD = 32'hDDDD_0004;
    localparam logic [31:0] DE = 32'hEEEE_0005;
    localparam logic [31:0] DF = 32'hFFFF_0006;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        s_valid, s_last, s_ready;
    logic [31:0] s_data;
    logic [3:0]  s_keep;
    logic        m_valid, m_last, m_ready;
    logic [63:0] m_data;
    logic [7:0]  m_keep;
    logic [15:0] pkt_cnt;

    logic        lo_s_valid, lo_s_last, lo_s_ready;
    logic [31:0] lo_s_data;
    logic [3:0]  lo_s_keep;
    logic        lo_m_valid, lo_m_last, lo_m_ready;
    logic [63:0] lo_m_data;
    logic [7:0]  lo_m_keep;
    logic [15:0] lo_pkt_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dma_if_32to64 #(.FIRST_IN_HIGH(1'b1), .CNT_W(16)) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .s0_axis_fromhost_tvalid (s_valid),
        .s0_axis_fromhost_tdata  (s_data),
        .s0_axis_fromhost_tkeep  (s_keep),
        .s0_axis_fromhost_tlast  (s_last),
        .s0_axis_fromhost_tready (s_ready),
        .m0_axis_fromhost_tvalid (m_valid),
        .m0_axis_fromhost_tdata  (m_data),
        .m0_axis_fromhost_tkeep  (m_keep),
        .m0_axis_fromhost_tlast  (m_last),
        .m0_axis_fromhost_tready (m_ready),
        .pkt_cnt                 (pkt_cnt)
    );

    dma_if_32to64 #(.FIRST_IN_HIGH(1'b0), .CNT_W(16)) dut_lo (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .s0_axis_fromhost_tvalid (lo_s_valid),
        .s0_axis_fromhost_tdata  (lo_s_data),
        .s0_axis_fromhost_tkeep  (lo_s_keep),
        .s0_axis_fromhost_tlast  (lo_s_last),
        .s0_axis_fromhost_tready (lo_s_ready),
        .m0_axis_fromhost_tvalid (lo_m_valid),
        .m0_axis_fromhost_tdata  (lo_m_data),
        .m0_axis_fromhost_tkeep  (lo_m_keep),
        .m0_axis_fromhost_tlast  (lo_m_last),
        .m0_axis_fromhost_tready (lo_m_ready),
        .pkt_cnt                 (lo_pkt_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] d, input logic [3:0] k, input logic l);
        s_valid = 1'b1;
        s_data  = d;
        s_keep  = k;
        s_last  = l;
    endtask

    task automatic idle();
        s_valid = 1'b0;
        s_data  = '0;
        s_keep  = '0;
        s_last  = 1'b0;
    endtask

    task automatic lo_drive(input logic v, input logic [31:0] d, input logic [3:0] k, input logic l);
        lo_s_valid = v;
        lo_s_data  = d;
        lo_s_keep  = k;
        lo_s_last  = l;
    endtask

    initial begin
        rst_n      = 1'b0;
        m_ready    = 1'b1;
        lo_m_ready = 1'b1;
        idle();
        lo_drive(1'b0, '0, '0, 1'b0);
        tick();
        tick();

        // Reset state
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_data", m_data, 64'd0);
        chk("rst_m_keep", 64'(m_keep), 64'd0);
        chk("rst_m_last", 64'(m_last), 64'd0);
        chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        chk("rst_s_ready", 64'(s_ready), 64'd1);
        rst_n = 1'b1;
        tick();

        // T1: A,B,C,D last on D
        drive(DA, 4'hf, 1'b0); tick();
        chk("t1_after_A_valid", 64'(m_valid), 64'd0);
        drive(DB, 4'hf, 1'b0); tick();
        chk("t1_AB_valid", 64'(m_valid), 64'd1);
        chk("t1_AB_data", m_data, {DA, DB});
        chk("t1_AB_keep", 64'(m_keep), 64'hff);
        chk("t1_AB_last", 64'(m_last), 64'd0);
        drive(DC, 4'hf, 1'b0); tick();
        chk("t1_after_C_valid", 64'(m_valid), 64'd0);
        drive(DD, 4'hf, 1'b1); tick();
        chk("t1_CD_valid", 64'(m_valid), 64'd1);
        chk("t1_CD_data", m_data, {DC, DD});
        chk("t1_CD_keep", 64'(m_keep), 64'hff);
        chk("t1_CD_last", 64'(m_last), 64'd1);
        idle(); tick();
        chk("t1_drain_valid", 64'(m_valid), 64'd0);
        chk("t1_pkt_cnt", 64'(pkt_cnt), 64'd1);

        // T2: odd-length packet A,B,C last on C
        drive(DA, 4'hf, 1'b0); tick();
        drive(DB, 4'hf, 1'b0); tick();
        chk("t2_AB_data", m_data, {DA, DB});
        chk("t2_AB_last", 64'(m_last), 64'd0);
        drive(DC, 4'hf, 1'b1); tick();
        chk("t2_C_valid", 64'(m_valid), 64'd1);
        chk("t2_C_data", m_data, {DC, 32'h0});
        chk("t2_C_keep", 64'(m_keep), 64'hf0);
        chk("t2_C_last", 64'(m_last), 64'd1);
        idle(); tick();
        chk("t2_pkt_cnt", 64'(pkt_cnt), 64'd2);

        // T3: single sparse dword
        drive(32'h1122_3344, 4'h3, 1'b1); tick();
        chk("t3_valid", 64'(m_valid), 64'd1);
        chk("t3_data", m_data, 64'h1122_3344_0000_0000);
        chk("t3_keep", 64'(m_keep), 64'h30);
        chk("t3_last", 64'(m_last), 64'd1);
        idle(); tick();
        chk("t3_pkt_cnt", 64'(pkt_cnt), 64'd3);

        // T4: downstream stall for 5 cycles with C waiting at the input
        m_ready = 1'b0;
        drive(DA, 4'hf, 1'b0); tick();
        drive(DB, 4'hf, 1'b0); tick();
        chk("t4_AB_valid", 64'(m_valid), 64'd1);
        drive(DC, 4'hf, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_stall_s_ready", 64'(s_ready), 64'd0);
            chk("t4_stall_valid", 64'(m_valid), 64'd1);
            chk("t4_stall_data", m_data, {DA, DB});
        end
        m_ready = 1'b1;
        #1;
        chk("t4_release_s_ready", 64'(s_ready), 64'd1);
        tick();
        chk("t4_after_release_valid", 64'(m_valid), 64'd0);
        drive(DD, 4'hf, 1'b1); tick();
        chk("t4_CD_data", m_data, {DC, DD});
        chk("t4_CD_last", 64'(m_last), 64'd1);
        idle(); tick();
        chk("t4_pkt_cnt", 64'(pkt_cnt), 64'd4);

        // T5: reset while A is held in S_HALF
        drive(DA, 4'hf, 1'b0); tick();
        idle();
        rst_n = 1'b0;
        #2;
        chk("t5_rst_valid", 64'(m_valid), 64'd0);
        chk("t5_rst_data", m_data, 64'd0);
        chk("t5_rst_keep", 64'(m_keep), 64'd0);
        chk("t5_rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        tick();
        rst_n = 1'b1;
        drive(DE, 4'hf, 1'b0); tick();
        chk("t5_after_E_valid", 64'(m_valid), 64'd0);
        drive(DF, 4'hf, 1'b1); tick();
        chk("t5_EF_valid", 64'(m_valid), 64'd1);
        chk("t5_EF_data", m_data, {DE, DF});
        chk("t5_EF_keep", 64'(m_keep), 64'hff);
        chk("t5_EF_last", 64'(m_last), 64'd1);
        idle(); tick();
        chk("t5_pkt_cnt", 64'(pkt_cnt), 64'd1);

        // T6: low-first packing and 16-bit counter wrap
        lo_drive(1'b1, DA, 4'hf, 1'b0); tick();
        lo_drive(1'b1, DB, 4'hf, 1'b1); tick();
        chk("t6_lo_AB_data", lo_m_data, {DB, DA});
        chk("t6_lo_AB_keep", 64'(lo_m_keep), 64'hff);
        chk("t6_lo_AB_last", 64'(lo_m_last), 64'd1);
        lo_drive(1'b1, DC, 4'h7, 1'b1); tick();
        chk("t6_lo_single_data", lo_m_data, {32'h0, DC});
        chk("t6_lo_single_keep", 64'(lo_m_keep), 64'h07);
        lo_drive(1'b0, '0, '0, 1'b0); tick();
        chk("t6_lo_pkt_cnt", 64'(lo_pkt_cnt), 64'd2);
        lo_drive(1'b1, DD, 4'hf, 1'b1);
        for (int i = 0; i < 65533; i++) begin
            tick();
        end
        chk("t6_stream_valid", 64'(lo_m_valid), 64'd1);
        lo_drive(1'b0, '0, '0, 1'b0); tick();
        chk("t6_cnt_allones", 64'(lo_pkt_cnt), 64'hffff);
        lo_drive(1'b1, DE, 4'hf, 1'b1); tick();
        lo_drive(1'b0, '0, '0, 1'b0); tick();
        chk("t6_cnt_wrap", 64'(lo_pkt_cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
